// File: rtl/mem_arb_ctrl_if.sv
// Request/response bundle between the requesting channels and the RAM arbiter.
// Channel k occupies slice k of every packed per-channel field.
interface mem_arb_ctrl_if #(
    parameter int NUM_CH    = 2,
    parameter int MAX_BYTES = 4
);
    localparam int LEN_W = $clog2(MAX_BYTES) + 1;

    logic [NUM_CH-1:0]             req_valid;
    logic [NUM_CH-1:0]             req_wr;
    logic [NUM_CH*32-1:0]          req_addr;
    logic [NUM_CH*LEN_W-1:0]       req_len;
    logic [NUM_CH*MAX_BYTES*8-1:0] req_wdata;
    logic [NUM_CH-1:0]             resp_done;
    logic [MAX_BYTES*8-1:0]        resp_rdata;

    modport master (
        output req_valid, req_wr, req_addr, req_len, req_wdata,
        input  resp_done, resp_rdata
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_len, req_wdata,
        output resp_done, resp_rdata
    );
endinterface

// File: rtl/mem_arb_ctrl.sv
// Round-robin arbiter serialising multi-byte channel requests onto a byte-wide RAM port.
// Read of L bytes completes in L+2 cycles, write in L+1; rdy_in freezes and replays, IO writes wait on io_buffer_full.
module mem_arb_ctrl #(
    parameter int          NUM_CH    = 2,
    parameter int          MAX_BYTES = 4,
    parameter logic [31:0] IO_BOUND  = 32'h30000
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy_in,
    input  logic          io_buffer_full,
    input  logic [7:0]    mem_din,
    output logic [7:0]    mem_dout,
    output logic [31:0]   mem_a,
    output logic          mem_wr,
    mem_arb_ctrl_if.slave bus,
    output logic          busy
);
    localparam int LEN_W = $clog2(MAX_BYTES) + 1;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int IDX_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t                 state;
    logic [CH_W-1:0]        ptr;
    logic [CH_W-1:0]        gnt;
    logic [31:0]            cur_addr;
    logic [LEN_W-1:0]       cur_len;
    logic [MAX_BYTES*8-1:0] cur_wdata;
    logic [LEN_W-1:0]       iss_idx;
    logic [LEN_W-1:0]       cap_idx;
    logic                   iss_vld;
    logic                   rd_pend;
    logic                   rewind;
    logic [NUM_CH-1:0]      resp_done_q;
    logic [MAX_BYTES*8-1:0] resp_rdata_q;

    logic                   gnt_found;
    logic [CH_W-1:0]        gnt_idx;
    logic [CH_W-1:0]        ptr_nxt;
    logic [LEN_W-1:0]       raw_len;
    logic [LEN_W-1:0]       gnt_len;
    logic [31:0]            gnt_addr;
    logic [MAX_BYTES*8-1:0] gnt_wdata;
    logic [NUM_CH-1:0]      gnt_onehot;
    logic [LEN_W-1:0]       wr_idx_nxt;
    logic [31:0]            wr_addr_nxt;
    logic [7:0]             wr_byte_nxt;

    assign bus.resp_done  = resp_done_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign gnt_onehot     = NUM_CH'(1) << gnt;

    // Scan downward so the channel closest to ptr is the last (winning) hit.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (bus.req_valid[(int'(ptr) + i) % NUM_CH]) begin
                gnt_found = 1'b1;
                gnt_idx   = CH_W'((int'(ptr) + i) % NUM_CH);
            end
        end
        ptr_nxt   = CH_W'((int'(gnt_idx) + 1) % NUM_CH);
        raw_len   = bus.req_len[gnt_idx*LEN_W +: LEN_W];
        gnt_addr  = bus.req_addr[gnt_idx*32 +: 32];
        gnt_wdata = bus.req_wdata[gnt_idx*MAX_BYTES*8 +: MAX_BYTES*8];
        if (raw_len == '0)
            gnt_len = LEN_W'(1);
        else if (raw_len > LEN_W'(MAX_BYTES))
            gnt_len = LEN_W'(MAX_BYTES);
        else
            gnt_len = raw_len;
    end

    // A write byte is retired only in a cycle where mem_wr was actually high.
    always_comb begin
        wr_idx_nxt  = mem_wr ? iss_idx + LEN_W'(1) : iss_idx;
        wr_addr_nxt = cur_addr + 32'(wr_idx_nxt);
        wr_byte_nxt = 8'(cur_wdata >> {wr_idx_nxt, 3'b000});
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state        <= IDLE;
            ptr          <= '0;
            gnt          <= '0;
            cur_addr     <= '0;
            cur_len      <= '0;
            cur_wdata    <= '0;
            iss_idx      <= '0;
            cap_idx      <= '0;
            iss_vld      <= 1'b0;
            rd_pend      <= 1'b0;
            rewind       <= 1'b0;
            mem_a        <= '0;
            mem_dout     <= '0;
            mem_wr       <= 1'b0;
            resp_done_q  <= '0;
            resp_rdata_q <= '0;
            busy         <= 1'b0;
        end else if (!rdy_in) begin
            // Data returning during a pause is lost, so reads replay from cap_idx.
            mem_wr      <= 1'b0;
            resp_done_q <= '0;
            if (state == READ) begin
                rd_pend <= 1'b0;
                rewind  <= 1'b1;
            end
        end else begin
            case (state)
                IDLE: begin
                    mem_wr <= 1'b0;
                    if (gnt_found) begin
                        gnt          <= gnt_idx;
                        ptr          <= ptr_nxt;
                        cur_addr     <= gnt_addr;
                        cur_len      <= gnt_len;
                        cur_wdata    <= gnt_wdata;
                        iss_idx      <= '0;
                        cap_idx      <= '0;
                        rd_pend      <= 1'b0;
                        rewind       <= 1'b0;
                        mem_a        <= gnt_addr;
                        resp_rdata_q <= '0;
                        busy         <= 1'b1;
                        if (bus.req_wr[gnt_idx]) begin
                            state    <= WRITE;
                            iss_vld  <= 1'b0;
                            mem_dout <= gnt_wdata[7:0];
                            mem_wr   <= !((gnt_addr >= IO_BOUND) && io_buffer_full);
                        end else begin
                            state   <= READ;
                            iss_vld <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (rewind) begin
                        rewind  <= 1'b0;
                        rd_pend <= 1'b0;
                        iss_vld <= 1'b1;
                        iss_idx <= cap_idx;
                        mem_a   <= cur_addr + 32'(cap_idx);
                    end else begin
                        rd_pend <= iss_vld;
                        if (iss_vld) begin
                            if (iss_idx + LEN_W'(1) == cur_len) begin
                                iss_vld <= 1'b0;
                            end else begin
                                iss_idx <= iss_idx + LEN_W'(1);
                                mem_a   <= cur_addr + 32'(iss_idx + LEN_W'(1));
                            end
                        end
                        if (rd_pend) begin
                            resp_rdata_q[{cap_idx[IDX_W-1:0], 3'b000} +: 8] <= mem_din;
                            cap_idx <= cap_idx + LEN_W'(1);
                            if (cap_idx + LEN_W'(1) == cur_len) begin
                                state       <= DONE;
                                resp_done_q <= gnt_onehot;
                                rd_pend     <= 1'b0;
                            end
                        end
                    end
                end
                WRITE: begin
                    if (mem_wr && (iss_idx + LEN_W'(1) == cur_len)) begin
                        mem_wr      <= 1'b0;
                        state       <= DONE;
                        resp_done_q <= gnt_onehot;
                    end else begin
                        iss_idx  <= wr_idx_nxt;
                        mem_a    <= wr_addr_nxt;
                        mem_dout <= wr_byte_nxt;
                        // io_buffer_full lags one cycle, so every IO byte is followed by a gap.
                        if (mem_wr && (mem_a >= IO_BOUND))
                            mem_wr <= 1'b0;
                        else
                            mem_wr <= !((wr_addr_nxt >= IO_BOUND) && io_buffer_full);
                    end
                end
                DONE: begin
                    if (resp_done_q != '0) begin
                        resp_done_q <= '0;
                        state       <= IDLE;
                        busy        <= 1'b0;
                    end else begin
                        resp_done_q <= gnt_onehot;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Directed bench for mem_arb_ctrl with a byte RAM model and a completion scoreboard.
module tb_mem_arb_ctrl;
    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        io_buffer_full;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        busy;

    mem_arb_ctrl_if #(.NUM_CH(2), .MAX_BYTES(4)) bus ();

    mem_arb_ctrl #(.NUM_CH(2), .MAX_BYTES(4), .IO_BOUND(32'h30000)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .io_buffer_full (io_buffer_full),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .bus            (bus),
        .busy           (busy)
    );

    typedef struct packed {
        logic [1:0]  ch;
        logic        wr;
        logic [31:0] rdata;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         n_assert = 0;
    int         n_fail   = 0;
    logic [7:0] ram [0:1023];

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // RAM model: preloaded while reset is held, data returned one cycle after the address.
    always @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < 1024; i++) ram[i] <= 8'hA5;
            ram[10'h100] <= 8'h11;
            ram[10'h101] <= 8'h22;
            ram[10'h102] <= 8'h33;
            ram[10'h103] <= 8'h44;
            ram[10'h007] <= 8'hFF;
            ram[10'h203] <= 8'h5E;
            mem_din      <= 8'h00;
        end else begin
            mem_din <= ram[mem_a[9:0]];
            if (mem_wr && mem_a < 32'h30000) ram[mem_a[9:0]] <= mem_dout;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk_in) begin
        if (!rst_in && bus.resp_done != 2'b00) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'(bus.resp_done), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("done_ch", 64'(bus.resp_done), 64'd1 << mon_e.ch);
                if (!mon_e.wr) chk("rdata", 64'(bus.resp_rdata), 64'(mon_e.rdata));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_req(input int ch, input logic wr, input logic [31:0] addr,
                           input logic [2:0] len, input logic [31:0] wdata);
        bus.req_valid[ch]         = 1'b1;
        bus.req_wr[ch]            = wr;
        bus.req_addr[ch*32 +: 32] = addr;
        bus.req_len[ch*3 +: 3]    = len;
        bus.req_wdata[ch*32 +: 32] = wdata;
    endtask

    task automatic push(input int ch, input logic wr, input logic [31:0] rdata);
        exp_t e;
        e.ch    = 2'(ch);
        e.wr    = wr;
        e.rdata = rdata;
        sb.push_back(e);
    endtask

    task automatic wait_done(input int max, output int t);
        t = 0;
        do begin
            tick();
            t++;
        end while (bus.resp_done == 2'b00 && t < max);
        chk("done_seen", 64'(bus.resp_done != 2'b00), 64'd1);
    endtask

    task automatic run_req(input string tag, input int ch, input logic wr, input logic [31:0] addr,
                           input logic [2:0] len, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int exp_t_cyc);
        int t;
        set_req(ch, wr, addr, len, wdata);
        push(ch, wr, rdata);
        wait_done(20, t);
        chk(tag, 64'(t), 64'(exp_t_cyc));
        bus.req_valid[ch] = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        tick();
        tick();
        rst_in = 1'b0;
    endtask

    initial begin
        int t;
        int wr_pat [1:9] = '{0, 0, 0, 0, 0, 1, 0, 1, 0};
        rst_in = 1'b1;
        rdy_in = 1'b1;
        io_buffer_full = 1'b0;
        bus.req_valid = '0;
        bus.req_wr    = '0;
        bus.req_addr  = '0;
        bus.req_len   = '0;
        bus.req_wdata = '0;
        do_reset();

        chk("rst_mem_a",  64'(mem_a), 64'd0);
        chk("rst_dout",   64'(mem_dout), 64'd0);
        chk("rst_wr",     64'(mem_wr), 64'd0);
        chk("rst_done",   64'(bus.resp_done), 64'd0);
        chk("rst_rdata",  64'(bus.resp_rdata), 64'd0);
        chk("rst_busy",   64'(busy), 64'd0);

        // Single 4-byte read: addresses in cycles 1-4, completion in cycle 6.
        set_req(0, 1'b0, 32'h100, 3'd4, 32'h0);
        push(0, 1'b0, 32'h44332211);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rd1_addr", 64'(mem_a), 64'(32'h100 + i));
            chk("rd1_wr", 64'(mem_wr), 64'd0);
            chk("rd1_busy", 64'(busy), 64'd1);
        end
        tick();
        chk("rd1_early", 64'(bus.resp_done), 64'd0);
        tick();
        chk("rd1_done", 64'(bus.resp_done), 64'd1);
        bus.req_valid[0] = 1'b0;
        tick();
        chk("rd1_idle_busy", 64'(busy), 64'd0);

        run_req("short_lat", 1, 1'b0, 32'h7, 3'd1, 32'h0, 32'h000000FF, 3);
        run_req("clamp_lat", 0, 1'b0, 32'h100, 3'd7, 32'h0, 32'h44332211, 6);
        run_req("len0_lat",  0, 1'b0, 32'h100, 3'd0, 32'h0, 32'h00000011, 3);
        run_req("wr_lat",    0, 1'b1, 32'h200, 3'd3, 32'h77CCBBAA, 32'h0, 4);
        run_req("rb_lat",    0, 1'b0, 32'h200, 3'd4, 32'h0, 32'h5ECCBBAA, 6);

        // Address wraps modulo 2^32.
        set_req(1, 1'b0, 32'hFFFF_FFFF, 3'd2, 32'h0);
        push(1, 1'b0, 32'h0000A5A5);
        tick();
        chk("wrap_a0", 64'(mem_a), 64'h0000_0000_FFFF_FFFF);
        tick();
        chk("wrap_a1", 64'(mem_a), 64'd0);
        wait_done(20, t);
        chk("wrap_lat", 64'(t), 64'd2);
        bus.req_valid[1] = 1'b0;
        tick();

        // IO write held off by io_buffer_full, then byte / gap / byte.
        io_buffer_full = 1'b1;
        set_req(1, 1'b1, 32'h30000, 3'd2, 32'h0000BBAA);
        push(1, 1'b1, 32'h0);
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c == 5) io_buffer_full = 1'b0;
            chk("io_wr", 64'(mem_wr), 64'(wr_pat[c]));
            if (c == 6) chk("io_b0", {24'h0, mem_a, mem_dout}, {24'h0, 32'h30000, 8'hAA});
            if (c == 8) chk("io_b1", {24'h0, mem_a, mem_dout}, {24'h0, 32'h30001, 8'hBB});
            chk("io_done", 64'(bus.resp_done), (c == 9) ? 64'd2 : 64'd0);
        end
        bus.req_valid[1] = 1'b0;
        tick();

        // rdy_in low for 3 cycles mid-read.
        set_req(0, 1'b0, 32'h100, 3'd4, 32'h0);
        push(0, 1'b0, 32'h44332211);
        tick();
        tick();
        chk("pz_addr", 64'(mem_a), 64'h101);
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("pz_hold", {mem_a, 6'h0, bus.resp_done, mem_wr}, {32'h101, 6'h0, 2'b00, 1'b0});
        end
        rdy_in = 1'b1;
        wait_done(30, t);
        chk("pz_delay", 64'((5 + t) >= 9 && (5 + t) <= 14), 64'd1);
        bus.req_valid[0] = 1'b0;
        tick();

        // Round robin from reset: both channels requesting continuously.
        do_reset();
        set_req(0, 1'b0, 32'h100, 3'd2, 32'h0);
        set_req(1, 1'b0, 32'h7, 3'd1, 32'h0);
        for (int k = 0; k < 4; k++) push(k % 2, 1'b0, (k % 2 == 0) ? 32'h2211 : 32'hFF);
        for (int k = 0; k < 4; k++) begin
            wait_done(20, t);
            chk("rr_ch", 64'(bus.resp_done), (k % 2 == 0) ? 64'd1 : 64'd2);
        end
        bus.req_valid = 2'b00;
        tick();

        // Single requester regranted after DONE plus one IDLE cycle.
        set_req(1, 1'b0, 32'h7, 3'd1, 32'h0);
        for (int k = 0; k < 3; k++) push(1, 1'b0, 32'hFF);
        wait_done(20, t);
        chk("solo_first", 64'(t), 64'd3);
        for (int k = 0; k < 2; k++) begin
            wait_done(20, t);
            chk("solo_gap", 64'(t), 64'd4);
        end
        bus.req_valid[1] = 1'b0;
        tick();

        // Asynchronous reset during byte 2 of a write.
        set_req(0, 1'b1, 32'h210, 3'd4, 32'h44332211);
        tick();
        tick();
        tick();
        chk("rst_pre", {mem_a, 7'h0, mem_wr}, {32'h212, 7'h0, 1'b1});
        #2 rst_in = 1'b1;
        #1;
        chk("arst_wr", 64'(mem_wr), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(bus.resp_done), 64'd0);
        bus.req_valid = 2'b00;
        tick();
        rst_in = 1'b0;
        set_req(0, 1'b0, 32'h100, 3'd1, 32'h0);
        set_req(1, 1'b0, 32'h7, 3'd1, 32'h0);
        push(0, 1'b0, 32'h11);
        wait_done(20, t);
        chk("arst_prio", 64'(bus.resp_done), 64'd1);
        bus.req_valid = 2'b00;
        tick();
        tick();
        tick();
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arb_ctrl.md
Name: mem_arb_ctrl

Overview:
Parametrised successor to the single-client RAM controller. Arbitrates NUM_CH request channels (instruction fetcher, LSB load/store, future cache refill) onto the single byte-wide RAM port. Each request is a multi-byte read or write of up to MAX_BYTES. Requests are serialised one byte per cycle, with round-robin fairness, rdy_in pause/replay and IO-buffer back-pressure.

Parameters:
NUM_CH, 2, number of request channels; index 0 has the highest priority after reset.
MAX_BYTES, 4, maximum bytes per request; power of two, at least 1.
LEN_W, $clog2(MAX_BYTES)+1, width of a per-channel length field (derived; not overridden).
IO_BOUND, 32'h30000, addresses at or above this value are IO-mapped.

Ports:
clk_in  in  1  clock
rst_in  in  1  asynchronous active-high reset
rdy_in  in  1  global ready; low freezes the controller
io_buffer_full  in  1  UART buffer full; blocks IO writes
mem_din  in  8  RAM read data; valid one cycle after mem_a is issued
mem_dout  out  8  RAM write data
mem_a  out  32  RAM byte address
mem_wr  out  1  1 = write this cycle
req_valid  in  NUM_CH  per-channel request; held until resp_done
req_wr  in  NUM_CH  1 = write, 0 = read
req_addr  in  NUM_CH*32  start byte address; channel k occupies [32k+31:32k]
req_len  in  NUM_CH*LEN_W  byte count, 1..MAX_BYTES
req_wdata  in  NUM_CH*MAX_BYTES*8  write data, little-endian (byte 0 at lowest address)
resp_done  out  NUM_CH  one-cycle completion pulse to the granted channel
resp_rdata  out  MAX_BYTES*8  read data, shared; valid while resp_done is high
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous) sets:
  - state = IDLE
  - mem_a = 0, mem_dout = 0, mem_wr = 0
  - resp_done = 0, resp_rdata = 0, busy = 0
  - round-robin pointer = 0
  - A reset mid-transaction aborts it; no resp_done is produced.
- States: IDLE, READ, WRITE, DONE. All outputs are registered.
- IDLE:
  - Scan req_valid starting at the pointer and grant the first set bit k.
  - Latch wr, addr, len and wdata for channel k; set pointer = (k+1) mod NUM_CH.
  - Go to READ or WRITE. If no request is pending, stay in IDLE with mem_wr = 0.
- req_len handling:
  - req_len of 0 is treated as 1.
  - req_len greater than MAX_BYTES is clamped to MAX_BYTES.
- Address generation: byte i uses addr+i, wrapping modulo 2^32.
- READ, for length L:
  - Cycles 1..L after the grant edge: mem_a = addr+i, mem_wr = 0.
  - The byte returned on mem_din in cycle c+1 is stored into resp_rdata[8i+7:8i].
  - Bytes at or above L read as zero (zero-extended; the LSB sign-extends).
  - resp_done is high in cycle L+2.
- WRITE, for length L:
  - Cycles 1..L: mem_a = addr+i, mem_dout = wdata byte i, mem_wr = 1.
  - resp_done is high in cycle L+1.
- IO write back-pressure: a write byte with addr+i >= IO_BOUND behaves as follows.
  - Issued only when io_buffer_full = 0; otherwise mem_wr = 0 and the byte index holds.
  - After every IO byte written, the controller inserts one cycle with mem_wr = 0, because io_buffer_full lags by one cycle.
  - IO reads are not throttled.
- DONE:
  - resp_done[k] = 1 for exactly one cycle; no grant is made in this cycle.
  - The next state is IDLE.
  - The requester must deassert req_valid in the cycle after it sees resp_done, so it is not regranted.
- rdy_in = 0:
  - All state, the pointer and the byte indices are frozen; mem_wr is forced to 0 and mem_a holds.
  - Any read byte whose data cycle falls in the pause is discarded.
  - On resume, the issue index rewinds to the first uncaptured byte and that address is re-issued.
  - resp_done never asserts while rdy_in = 0; it is delayed to the first ready cycle.
- Simultaneous requests: exactly one grant per IDLE cycle, chosen by rotating priority. No channel waits more than NUM_CH-1 transactions.
- Request payload is sampled only at the grant edge. Changes to it while the channel is granted are ignored.

Test Plan:
- Single read: ch0 requests len=4 at 0x100, RAM bytes 11,22,33,44 -> mem_a = 0x100..0x103 in cycles 1-4, resp_done[0] in cycle 6, resp_rdata = 0x44332211.
- Short read zero-fill: ch1 requests len=1 at 0x7, byte 0xFF -> resp_rdata = 0x000000FF, resp_done[1] in cycle 3.
- Round-robin: ch0 and ch1 both assert continuously from reset -> grants alternate 0,1,0,1; with a single requester ch1, it is regranted after each DONE plus one IDLE cycle.
- IO back-pressure: ch1 writes len=2 to 0x30000 with io_buffer_full high for 5 cycles -> mem_wr stays 0 for those cycles, then one byte, one idle cycle, then the second byte; resp_done after the second byte.
- rdy_in pause: rdy_in drops for 3 cycles in the middle of a len=4 read -> no lost or duplicated bytes, the same rdata as the unpaused run, resp_done delayed by at least 3 cycles.
- Async reset mid-write: assert rst_in between clock edges during byte 2 -> mem_wr = 0 and busy = 0 immediately; no resp_done; the next request starts cleanly from ch0 priority.
